// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scan-side controller for the Bingo board display.
// It decodes h_cnt/v_cnt into board coordinates and drives the sprite ROM address.
// It emits per-pixel cell attributes that line up with the ROM read data.
// Board state is shadowed only at the frame boundary, under a req/ack handshake.
// Optional feature: define DISPLAY_LINE_EN to shadow the line input and drive cell_line.
module display_scan_ctrl #(
  parameter int unsigned ROM_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   h_cnt,
  input  logic [9:0]   v_cnt,
  input  logic         valid,
  input  logic [124:0] map,
  input  logic [24:0]  circle,
  input  logic [11:0]  line,
  input  logic         upd_req,
  output logic         upd_ack,
  output logic         frame_tick,
  output logic [11:0]  pix_addr,
  output logic         in_window,
  output logic         out_valid,
  output logic [4:0]   cell_num,
  output logic         cell_circle,
  output logic         cell_line
);

  typedef enum logic [1:0] {StIdle, StPending, StDone} state_e;

  logic       win0, boundary, capture;
  logic [9:0] dx_full, dy_full;
  logic [8:0] dx, dy;
  state_e     state_q, state_d;

  logic [124:0] snap_map_q;
  logic [24:0]  snap_circle_q;

  logic [11:0] addr_q;
  logic [2:0]  bx_q, by_q;
  logic        win_q, valid_q;

  logic [4:0] cell_k;
  logic [6:0] cell_base;
  logic [5:0] px, py;
  logic [4:0] num_d;
  logic       circle_d, line_d;

  // Attribute bundle {in_window, out_valid, cell_num, cell_circle, cell_line}
  logic [8:0] attr_d;
  logic [8:0] attr_pipe [ROM_LAT];

  logic unused_bits;

  // Window decode; coordinates collapse to 0 outside the board
  always_comb begin
    win0     = (h_cnt >= 10'd160) && (h_cnt < 10'd480) &&
               (v_cnt >= 10'd80) && (v_cnt < 10'd400);
    dx_full  = h_cnt - 10'd160;
    dy_full  = v_cnt - 10'd80;
    dx       = win0 ? dx_full[8:0] : 9'd0;
    dy       = win0 ? dy_full[8:0] : 9'd0;
    boundary = (h_cnt == 10'd0) && (v_cnt == 10'd480);
  end

  // Snapshot handshake: capture only on a boundary, at most once per request
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (upd_req) begin
          if (boundary) begin
            capture = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (boundary) begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!upd_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, handshake/frame pulses and shadow copy of the board
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      upd_ack       <= 1'b0;
      frame_tick    <= 1'b0;
      snap_map_q    <= '0;
      snap_circle_q <= '0;
    end else begin
      state_q    <= state_d;
      upd_ack    <= capture;
      frame_tick <= boundary;
      if (capture) begin
        snap_map_q    <= map;
        snap_circle_q <= circle;
      end
    end
  end

`ifdef DISPLAY_LINE_EN
  logic [11:0] snap_line_q;

  // Line shadow, captured together with the rest of the board
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_line_q <= '0;
    end else if (capture) begin
      snap_line_q <= line;
    end
  end

  // Line hit test on the stage-1 coordinates; 7-bit sums avoid 6-bit wrap
  always_comb begin
    line_d = 1'b0;
    if (snap_line_q[{1'b0, by_q}] && (py == 6'd31 || py == 6'd32)) line_d = 1'b1;
    if (snap_line_q[{1'b0, bx_q} + 4'd5] && (px == 6'd31 || px == 6'd32)) line_d = 1'b1;
    if (snap_line_q[10] && (bx_q == by_q) &&
        (({1'b0, px} == {1'b0, py}) || ({1'b0, px} == {1'b0, py} + 7'd1) ||
         ({1'b0, py} == {1'b0, px} + 7'd1))) line_d = 1'b1;
    if (snap_line_q[11] && ({1'b0, bx_q} + {1'b0, by_q} == 4'd4) &&
        ({1'b0, px} + {1'b0, py} >= 7'd62) && ({1'b0, px} + {1'b0, py} <= 7'd64))
      line_d = 1'b1;
    line_d = line_d & win_q;
  end

  assign unused_bits = dx_full[9] ^ dy_full[9];
`else
  assign line_d      = 1'b0;
  assign unused_bits = dx_full[9] ^ dy_full[9] ^ (^line);
`endif

  // Stage 1: ROM address and the coordinates needed for attribute lookup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      win_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= {dy[5:0], dx[5:0]};
      bx_q    <= dx[8:6];
      by_q    <= dy[8:6];
      win_q   <= win0;
      valid_q <= valid;
    end
  end

  assign pix_addr = addr_q;

  // Cell lookup from the shadow copy; attributes forced to 0 off-board
  always_comb begin
    px        = addr_q[5:0];
    py        = addr_q[11:6];
    cell_k    = {2'b0, by_q} * 5'd5 + {2'b0, bx_q};
    cell_base = {2'b0, cell_k} * 7'd5;
    num_d     = win_q ? snap_map_q[cell_base +: 5] : 5'd0;
    circle_d  = win_q & snap_circle_q[cell_k];
    attr_d    = {win_q, valid_q, num_d, circle_d, line_d};
  end

  // ROM_LAT-deep delay so attributes coincide with ROM read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) attr_pipe[i] <= '0;
    end else begin
      attr_pipe[0] <= attr_d;
      for (int unsigned i = 1; i < ROM_LAT; i++) attr_pipe[i] <= attr_pipe[i-1];
    end
  end

  assign {in_window, out_valid, cell_num, cell_circle, cell_line} = attr_pipe[ROM_LAT-1];

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Scan-side controller for the Bingo board display. It runs on the 25 MHz pixel clock and decodes the VGA controller's `h_cnt`/`v_cnt` into window, block and in-block pixel coordinates. It drives the sprite ROM address and emits per-pixel cell attributes aligned to the ROM's read latency. Board state (`map`, `circle`, `line`) is captured into a shadow copy only at a frame boundary, under a req/ack handshake with the game logic, so the picture never tears.

## Interface
- `ROM_LAT`, 1: block-ROM read latency in cycles (1..3).
- `clk`  in  1  pixel clock (25 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `h_cnt`  in  10  horizontal count from the VGA controller.
- `v_cnt`  in  10  vertical count from the VGA controller.
- `valid`  in  1  active-video flag from the VGA controller.
- `map`  in  125  25 cells × 5-bit number; cell k = bits [5k+4:5k], k = 5·row + col.
- `circle`  in  25  per-cell circled flag, bit k.
- `line`  in  12  completed lines: bits 0–4 rows, 5–9 cols, 10 main diagonal, 11 anti-diagonal.
- `upd_req`  in  1  game logic requests a snapshot; level, held until `upd_ack`.
- `upd_ack`  out  1  one-cycle pulse: snapshot taken.
- `frame_tick`  out  1  one-cycle pulse at the frame boundary.
- `pix_addr`  out  12  ROM address {pixel_y[5:0], pixel_x[5:0]}.
- `in_window`  out  1  pixel inside the 320×320 board, ROM-aligned.
- `out_valid`  out  1  `valid` delayed to ROM alignment.
- `cell_num`  out  5  snapshot number of the current cell, ROM-aligned.
- `cell_circle`  out  1  snapshot circle flag of the current cell, ROM-aligned.
- `cell_line`  out  1  pixel lies on a completed line, ROM-aligned.

## Operation
- Window: h ∈ [160,480), v ∈ [80,400).
  - dx = h−160, dy = v−80.
  - block_x = dx[8:6], block_y = dy[8:6], pixel_x = dx[5:0], pixel_y = dy[5:0].
  - Outside the window: coordinates and `pix_addr` are forced to 0, and all attributes are 0.
- Frame boundary: h_cnt==0 && v_cnt==480. `frame_tick` is registered, so it goes high the cycle after that input.
- Snapshot FSM states: IDLE, PENDING, DONE.
  - IDLE → PENDING: `upd_req`=1 on a cycle that is not a boundary.
  - IDLE, boundary with `upd_req`=1: latch snapshot, pulse `upd_ack`, go to DONE (same-cycle capture).
  - PENDING → DONE at the next boundary: snapshot ← {map, circle, line}, pulse `upd_ack`.
  - DONE → IDLE when `upd_req`=0. No new capture happens while `upd_req` stays high.
- All attributes are read from the snapshot, never from the live inputs.
- `cell_line`, for cell (bx,by) at offset (px,py):
  - row r (bit r): by==r and py ∈ {31,32}.
  - col c (bit 5+c): bx==c and px ∈ {31,32}.
  - bit 10: bx==by and |px−py| ≤ 1.
  - bit 11: bx+by==4 and px+py ∈ {62,63,64}.
  - Result is the OR of all hits.
- Arithmetic: unsigned; dx and dy are 9 bits, valid only when inside the window.

## Timing
- `pix_addr` is registered 1 cycle after `h_cnt`/`v_cnt`.
- `in_window`, `out_valid`, `cell_num`, `cell_circle`, `cell_line` are registered 1+ROM_LAT cycles after `h_cnt`/`v_cnt`, so they coincide with ROM `douta`.
- Pipeline is free-running and has no stalls.
- Reset values:
  - All outputs 0.
  - Snapshot cleared (all cells number 0, no circles, no lines).
  - FSM in IDLE; pipeline registers cleared.
- Reset mid-frame or mid-handshake: a pending request is dropped and no `upd_ack` is issued. The requester must re-raise `upd_req`.
- At most one `upd_ack` per frame.

## Configuration
- `DISPLAY_LINE_EN` defined:
  - `line` is snapshotted.
  - `cell_line` is computed as above.
- `DISPLAY_LINE_EN` undefined:
  - No `line` shadow register is built.
  - `cell_line` is tied to 0.
  - Handshake, timing and all other outputs are unchanged.

## Test plan
- Reset mid-frame, release, scan a full frame with `upd_req`=0 → `cell_num`=0 and `cell_circle`=0 everywhere; `frame_tick` pulses exactly once per 800×525 cycles.
- Raise `upd_req` at v=200 with cell 7 = 5'd19 and circle[7]=1 → `upd_ack` one cycle after boundary (h=0,v=480). Next frame at h=160+64·2+10, v=80+64·1+10 → `cell_num`=19, `cell_circle`=1, 1+ROM_LAT cycles later.
- Change `map` mid-frame with no request → displayed `cell_num` stays unchanged for the whole frame.
- h=160+64·3+5, v=80+64·2+20 → `pix_addr`=12'h505 one cycle later. h=159 → `in_window`=0, `pix_addr`=0.
- line=12'h801, DISPLAY_LINE_EN set:
  - (bx0,by0,px10,py31) → `cell_line`=1.
  - (bx4,by0,px63,py0) → `cell_line`=1 (anti-diagonal).
  - (bx1,by1,px31,py31) → `cell_line`=0.
  - With the macro undefined, `cell_line`=0 at all of these points.
- Hold `upd_req` high across two boundaries → exactly one `upd_ack`; drop and re-raise → second ack at the following boundary.
